rvga_mem_arbiter: RTL and testbench
===================================

# rvga_mem_arbiter

Two-requester arbiter that shares the single cacheline-wide backing-memory port between the instruction-fetch cache (read-only) and the data cache (read/write). It sits between the core's cache layer and the memory model/controller. It serialises one outstanding transaction at a time: accept, issue, wait, return. All data transfers are `rvga_cacheline` (128 b) and all addresses are `rvga_word` (32 b).

## Interface
- `dc_priority_p`, default 0: 0 = round-robin on simultaneous requests; 1 = dcache always wins ties.
- `clk_i`  in  1  sole clock
- `reset_i`  in  1  asynchronous, active-high reset
- `ic_v_i` / `ic_ready_o`  in/out  1  icache request handshake
- `ic_addr_i`  in  32  icache read address
- `ic_v_o` / `ic_yumi_i`  out/in  1  icache response handshake
- `ic_data_o`  out  128  icache response line
- `dc_v_i` / `dc_ready_o`  in/out  1  dcache request handshake
- `dc_w_i`  in  1  1 = write line, 0 = read line
- `dc_addr_i`  in  32  dcache address
- `dc_data_i`  in  128  dcache write line
- `dc_v_o` / `dc_yumi_i`  out/in  1  dcache response handshake (reads and writes)
- `dc_data_o`  out  128  dcache response line
- `mem_v_o` / `mem_ready_i`  out/in  1  memory request handshake
- `mem_w_o`  out  1  write enable
- `mem_addr_o`  out  32  line-aligned address, bits [3:0] = 0
- `mem_data_o`  out  128  write line
- `mem_v_i` / `mem_yumi_o`  in/out  1  memory response handshake
- `mem_data_i`  in  128  response line

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: grant is computed from `ic_v_i`/`dc_v_i`. The winner's `*_ready_o`=1 and the loser's `*_ready_o`=0.
  - Transfer occurs on `v_i & ready_o`. Latch the owner, `w`, `{addr[31:4],4'b0}` and the write data, then go to ISSUE.
  - Icache requests latch `w`=0.
- Ready dependency: a requester's `ready_o` depends combinationally on the other requester's `v_i`, never on its own.
- Arbitration:
  - If only one requester is valid, it wins.
  - If both are valid and `dc_priority_p`=0, the requester not granted last time wins. `last_grant_r` updates on each accept.
  - If both are valid and `dc_priority_p`=1, dcache wins.
- ISSUE: `mem_v_o`=1 with the latched request. Go to WAIT on `mem_ready_i`; otherwise hold with the request stable.
- WAIT: `mem_yumi_o`=1. When `mem_v_i`=1, capture `mem_data_i` and go to RESP.
- RESP: the owner's `*_v_o`=1 with the captured line (write responses forward `mem_data_i` unchanged; dcache ignores it). Go to IDLE on the owner's `*_yumi_i`; otherwise hold.
- Flow control: no request is accepted outside IDLE, and `*_ready_o`=0 in ISSUE/WAIT/RESP.
- Ignored input: a `mem_v_i` outside WAIT is ignored.

## Timing
- Reset values: state=IDLE, `last_grant_r`=icache (so dcache wins the first tie), data/address registers=0.
  - `mem_v_o`, `mem_yumi_o`, `ic_v_o` and `dc_v_o` are 0.
  - `ic_data_o`, `dc_data_o`, `mem_addr_o`, `mem_data_o` and `mem_w_o` are 0.
- Reset mid-transaction abandons the transaction with no response. The memory side shares `reset_i`.
- Minimum latency, with `mem_ready_i` high and memory responding in the cycle after issue:
  - accept at cycle 0, `mem_v_o` at cycle 1;
  - `mem_v_i` at cycle 2, `*_v_o` at cycle 3;
  - if yumi is given at cycle 3, IDLE and the next accept are at cycle 4.
- Request fields and `mem_*` outputs are registered: no combinational path from `*_addr_i`/`*_data_i` to `mem_*`.
- Response outputs are registered: no path from `mem_data_i` to `*_data_o`.
- Request/response outputs (`*_v_o`, `mem_v_o`, data, address) stay stable while waiting on the handshake partner.
- Simultaneous events:
  - Yumi in RESP plus new `v_i` in the same cycle: the new request is not accepted until the following IDLE cycle.
  - Loser of a tie keeps `v_i` high and wins the next IDLE under round-robin.

## Structure
- Add to `rvga_types`:
  - `rvga_arb_state_e` enum (`e_rvga_arb_idle`, `e_rvga_arb_issue`, `e_rvga_arb_wait`, `e_rvga_arb_resp`, 2 b).
  - `rvga_mem_req` packed struct {`w`, `rvga_word addr`, `rvga_cacheline data`}.
  - `rvga_arb_owner_e` enum (`e_rvga_arb_ic`, `e_rvga_arb_dc`).
- Sub-module `rvga_rr_arb2`: two-input round-robin grant logic with a `last_grant` register. It honours `dc_priority_p` and has an enable that is asserted on accept.

## Test plan
- Icache read alone, address 0x0000_1234 -> `mem_addr_o`=0x0000_1230 and `mem_w_o`=0. Line 0xA5..A5 returns on `ic_data_o` at cycle 3; `dc_v_o` stays 0.
- Dcache write at 0x0000_2000 with data 0x1111…1111 -> `mem_w_o`=1 and `mem_data_o`=0x1111…1111. `dc_v_o` pulses after the memory response.
- Both valid every cycle, `dc_priority_p`=0 -> grants alternate dc, ic, dc, ic over 4 transactions.
- Both valid every cycle, `dc_priority_p`=1 -> 4 consecutive dcache grants and `ic_ready_o` never 1.
- `mem_ready_i` low for 5 cycles, then `mem_v_i` delayed 7 cycles, then `dc_yumi_i` delayed 3 cycles:
  - `mem_v_o`, address and data stay stable throughout ISSUE;
  - `dc_v_o` holds throughout RESP;
  - `*_ready_o` stays 0 throughout.
- Assert `reset_i` during WAIT -> all valids 0 in the same cycle (async). After release the arbiter accepts a fresh dcache request and no stale response appears.

Source files
------------

// File: rtl/rvga_mem_arbiter_pkg.sv
// rvga_mem_arbiter_pkg
//   Shared rvga types for the backing-memory arbiter: word/cacheline widths,
//   FSM state and owner enums, the latched memory request record, and the
//   line-alignment helper.
//   Ports: none (package).
package rvga_mem_arbiter_pkg;

  typedef logic [31:0]  rvga_word;
  typedef logic [127:0] rvga_cacheline;

  typedef enum logic [1:0] {
    e_rvga_arb_idle  = 2'd0,
    e_rvga_arb_issue = 2'd1,
    e_rvga_arb_wait  = 2'd2,
    e_rvga_arb_resp  = 2'd3
  } rvga_arb_state_e;

  typedef enum logic {
    e_rvga_arb_ic = 1'b0,
    e_rvga_arb_dc = 1'b1
  } rvga_arb_owner_e;

  typedef struct packed {
    logic          w;
    rvga_word      addr;
    rvga_cacheline data;
  } rvga_mem_req;

  localparam int unsigned rvga_line_offset_lp = 4;

  // Memory only understands whole lines, so the byte offset is dropped.
  function automatic rvga_word rvga_line_align(input rvga_word addr);
    return {addr[31:rvga_line_offset_lp], {rvga_line_offset_lp{1'b0}}};
  endfunction

endpackage

// File: rtl/rvga_mem_arbiter_if.sv
// rvga_mem_arbiter_if
//   Bundles the icache, dcache and memory handshakes seen by the arbiter.
//   slave  : arbiter view (drives *_ready_o, *_v_o, *_data_o, mem_*_o).
//   master : environment view (caches and memory model).
//   Signals: ic_v_i/ic_ready_o/ic_addr_i, ic_v_o/ic_yumi_i/ic_data_o,
//            dc_v_i/dc_ready_o/dc_w_i/dc_addr_i/dc_data_i,
//            dc_v_o/dc_yumi_i/dc_data_o,
//            mem_v_o/mem_ready_i/mem_w_o/mem_addr_o/mem_data_o,
//            mem_v_i/mem_yumi_o/mem_data_i.
interface rvga_mem_arbiter_if import rvga_mem_arbiter_pkg::*; ();

  logic          ic_v_i;
  logic          ic_ready_o;
  rvga_word      ic_addr_i;
  logic          ic_v_o;
  logic          ic_yumi_i;
  rvga_cacheline ic_data_o;

  logic          dc_v_i;
  logic          dc_ready_o;
  logic          dc_w_i;
  rvga_word      dc_addr_i;
  rvga_cacheline dc_data_i;
  logic          dc_v_o;
  logic          dc_yumi_i;
  rvga_cacheline dc_data_o;

  logic          mem_v_o;
  logic          mem_ready_i;
  logic          mem_w_o;
  rvga_word      mem_addr_o;
  rvga_cacheline mem_data_o;
  logic          mem_v_i;
  logic          mem_yumi_o;
  rvga_cacheline mem_data_i;

  modport slave (
    input  ic_v_i, ic_addr_i, ic_yumi_i,
    output ic_ready_o, ic_v_o, ic_data_o,
    input  dc_v_i, dc_w_i, dc_addr_i, dc_data_i, dc_yumi_i,
    output dc_ready_o, dc_v_o, dc_data_o,
    output mem_v_o, mem_w_o, mem_addr_o, mem_data_o, mem_yumi_o,
    input  mem_ready_i, mem_v_i, mem_data_i
  );

  modport master (
    output ic_v_i, ic_addr_i, ic_yumi_i,
    input  ic_ready_o, ic_v_o, ic_data_o,
    output dc_v_i, dc_w_i, dc_addr_i, dc_data_i, dc_yumi_i,
    input  dc_ready_o, dc_v_o, dc_data_o,
    input  mem_v_o, mem_w_o, mem_addr_o, mem_data_o, mem_yumi_o,
    output mem_ready_i, mem_v_i, mem_data_i
  );

endinterface

// File: rtl/rvga_mem_arbiter_rr_arb2.sv
// rvga_rr_arb2
//   Two-input grant logic for icache/dcache with a last-grant register.
//   Ports: clk_i, reset_i (async, active high); ic_v_i, dc_v_i request valids;
//          en_i pulses on an accepted request and updates last_grant_r;
//          ic_grant_o, dc_grant_o grants (caller qualifies with its idle state).
//   Each grant looks only at the other requester's valid, so a requester's
//   ready never depends on its own valid.
module rvga_rr_arb2 import rvga_mem_arbiter_pkg::*; #(
  parameter bit dc_priority_p = 1'b0
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic ic_v_i,
  input  logic dc_v_i,
  input  logic en_i,
  output logic ic_grant_o,
  output logic dc_grant_o
);

  rvga_arb_owner_e last_grant_r;
  logic            dc_wins_tie;

  always_comb begin
    dc_wins_tie = dc_priority_p ? 1'b1 : (last_grant_r == e_rvga_arb_ic);
    ic_grant_o  = ~dc_v_i | ~dc_wins_tie;
    dc_grant_o  = ~ic_v_i |  dc_wins_tie;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      last_grant_r <= e_rvga_arb_ic;
    end else if (en_i) begin
      last_grant_r <= (dc_v_i & dc_grant_o) ? e_rvga_arb_dc : e_rvga_arb_ic;
    end
  end

endmodule

// File: rtl/rvga_mem_arbiter.sv
// rvga_mem_arbiter
//   Shares one cacheline memory port between icache (read) and dcache
//   (read/write), one transaction at a time: accept, issue, wait, return.
//   Ports: clk_i, reset_i (async, active high); bus (rvga_mem_arbiter_if.slave)
//          carrying the icache, dcache and memory handshakes.
//   Parameter dc_priority_p: 0 = round-robin on ties, 1 = dcache wins ties.
//
//   state | meaning
//   IDLE  | ready offered to the arbitration winner, waiting for an accept
//   ISSUE | mem_v_o held with the latched request until mem_ready_i
//   WAIT  | mem_yumi_o held until mem_v_i, response line captured
//   RESP  | owner's *_v_o held with the captured line until its yumi
module rvga_mem_arbiter import rvga_mem_arbiter_pkg::*; #(
  parameter bit dc_priority_p = 1'b0
) (
  input logic               clk_i,
  input logic               reset_i,
  rvga_mem_arbiter_if.slave bus
);

  rvga_arb_state_e state_r, state_n;
  rvga_arb_owner_e owner_r;
  rvga_mem_req     req_r;
  rvga_cacheline   resp_r;

  logic ic_grant, dc_grant;
  logic idle, ic_accept, dc_accept, accept, resp_done;
  logic mem_v, mem_yumi, ic_v, dc_v;
  logic unused_addr_bits;

  rvga_rr_arb2 #(.dc_priority_p(dc_priority_p)) arb (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .ic_v_i     (bus.ic_v_i),
    .dc_v_i     (bus.dc_v_i),
    .en_i       (accept),
    .ic_grant_o (ic_grant),
    .dc_grant_o (dc_grant)
  );

  assign idle           = (state_r == e_rvga_arb_idle);
  assign bus.ic_ready_o = idle & ic_grant;
  assign bus.dc_ready_o = idle & dc_grant;
  assign ic_accept      = bus.ic_v_i & bus.ic_ready_o;
  assign dc_accept      = bus.dc_v_i & bus.dc_ready_o;
  assign accept         = ic_accept | dc_accept;
  assign resp_done      = (owner_r == e_rvga_arb_dc) ? bus.dc_yumi_i : bus.ic_yumi_i;

  // Byte offsets never reach memory.
  assign unused_addr_bits = ^{bus.ic_addr_i[3:0], bus.dc_addr_i[3:0]};

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= e_rvga_arb_idle;
    end else begin
      state_r <= state_n;
    end
  end

  always_comb begin
    state_n  = state_r;
    mem_v    = 1'b0;
    mem_yumi = 1'b0;
    ic_v     = 1'b0;
    dc_v     = 1'b0;
    case (state_r)
      e_rvga_arb_idle: begin
        if (accept) state_n = e_rvga_arb_issue;
      end
      e_rvga_arb_issue: begin
        mem_v = 1'b1;
        if (bus.mem_ready_i) state_n = e_rvga_arb_wait;
      end
      e_rvga_arb_wait: begin
        mem_yumi = 1'b1;
        if (bus.mem_v_i) state_n = e_rvga_arb_resp;
      end
      e_rvga_arb_resp: begin
        ic_v = (owner_r == e_rvga_arb_ic);
        dc_v = (owner_r == e_rvga_arb_dc);
        if (resp_done) state_n = e_rvga_arb_idle;
      end
      default: state_n = e_rvga_arb_idle;
    endcase
  end

  // Request is latched at accept so mem_* never sees the cache inputs
  // combinationally; the response line is registered for the same reason.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      owner_r <= e_rvga_arb_ic;
      req_r   <= '0;
      resp_r  <= '0;
    end else begin
      if (ic_accept) begin
        owner_r    <= e_rvga_arb_ic;
        req_r.w    <= 1'b0;
        req_r.addr <= rvga_line_align(bus.ic_addr_i);
        req_r.data <= '0;
      end else if (dc_accept) begin
        owner_r    <= e_rvga_arb_dc;
        req_r.w    <= bus.dc_w_i;
        req_r.addr <= rvga_line_align(bus.dc_addr_i);
        req_r.data <= bus.dc_data_i;
      end
      if ((state_r == e_rvga_arb_wait) && bus.mem_v_i) begin
        resp_r <= bus.mem_data_i;
      end
    end
  end

  assign bus.mem_v_o    = mem_v;
  assign bus.mem_yumi_o = mem_yumi;
  assign bus.mem_w_o    = req_r.w;
  assign bus.mem_addr_o = req_r.addr;
  assign bus.mem_data_o = req_r.data;
  assign bus.ic_v_o     = ic_v;
  assign bus.dc_v_o     = dc_v;
  assign bus.ic_data_o  = resp_r;
  assign bus.dc_data_o  = resp_r;

endmodule

// File: tb/tb_rvga_mem_arbiter.sv
// tb_rvga_mem_arbiter
//   Directed bench for rvga_mem_arbiter. A transaction-level model of the
//   arbiter is checked against every output on each falling edge; directed
//   tests add literal expectations on addresses, data, grants and latency.
//   A second instance with dcache priority covers the fixed-priority mode.
module tb_rvga_mem_arbiter;
  import rvga_mem_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rvga_mem_arbiter_if bus ();
  rvga_mem_arbiter_if bus_p ();

  rvga_mem_arbiter #(.dc_priority_p(1'b0)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  rvga_mem_arbiter #(.dc_priority_p(1'b1)) dut_p (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus_p)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  // Memory / consumer behaviour knobs
  int            ready_dly = 0;
  int            resp_dly  = 0;
  int            yumi_dly  = 0;
  bit            spurious  = 0;
  logic [127:0]  resp_line = '0;

  // Memory responder: stalls mem_ready_i, then delays the response.
  initial begin
    int mph;
    int mcnt;
    mph = 0;
    mcnt = 0;
    bus.mem_ready_i = 1'b0;
    bus.mem_v_i     = 1'b0;
    bus.mem_data_i  = '0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        bus.mem_ready_i = 1'b0;
        bus.mem_v_i     = 1'b0;
        mph = 0;
        mcnt = 0;
      end else begin
        case (mph)
          0: begin
            bus.mem_v_i = 1'b0;
            bus.mem_ready_i = 1'b0;
            if (bus.mem_v_o) begin
              if (mcnt == ready_dly) begin
                bus.mem_ready_i = 1'b1;
                mph = 1;
                mcnt = 0;
              end else begin
                mcnt++;
                if (spurious) begin
                  bus.mem_v_i = 1'b1;
                  bus.mem_data_i = {4{32'hBAD0_BAD0}};
                end
              end
            end
          end
          1: begin
            bus.mem_ready_i = 1'b0;
            if (mcnt == resp_dly) begin
              bus.mem_v_i = 1'b1;
              bus.mem_data_i = resp_line;
              mph = 2;
            end else begin
              mcnt++;
            end
          end
          default: begin
            bus.mem_v_i = 1'b0;
            mph = 0;
            mcnt = 0;
          end
        endcase
      end
    end
  end

  // Response consumer: yumi after yumi_dly cycles of *_v_o.
  initial begin
    int ycnt;
    ycnt = 0;
    bus.ic_yumi_i = 1'b0;
    bus.dc_yumi_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.ic_yumi_i = 1'b0;
      bus.dc_yumi_i = 1'b0;
      if (rst) begin
        ycnt = 0;
      end else if (bus.ic_v_o || bus.dc_v_o) begin
        if (ycnt == yumi_dly) begin
          bus.ic_yumi_i = bus.ic_v_o;
          bus.dc_yumi_i = bus.dc_v_o;
          ycnt = 0;
        end else begin
          ycnt++;
        end
      end else begin
        ycnt = 0;
      end
    end
  end

  // Transaction-level model: one outstanding request and where it stands.
  // m_stage: 0 = waiting for memory to take it, 1 = waiting for memory data,
  //          2 = waiting for the owner to consume the line.
  bit           m_busy    = 0;
  int           m_stage   = 0;
  bit           m_owner   = 0;  // 1 = dcache
  bit           m_last_dc = 0;
  logic         m_w       = 1'b0;
  logic [31:0]  m_addr    = '0;
  logic [127:0] m_data    = '0;
  logic [127:0] m_line    = '0;
  int           model_log[$];

  always @(negedge clk) begin
    bit dc_tie;
    bit e_icr;
    bit e_dcr;
    bit yumi;
    if (rst) begin
      chk("rst_mem_v",    bus.mem_v_o,    1'b0);
      chk("rst_mem_yumi", bus.mem_yumi_o, 1'b0);
      chk("rst_ic_v",     bus.ic_v_o,     1'b0);
      chk("rst_dc_v",     bus.dc_v_o,     1'b0);
      chk("rst_mem_w",    bus.mem_w_o,    1'b0);
      chk("rst_mem_addr", bus.mem_addr_o, 32'h0);
      chk("rst_mem_data", bus.mem_data_o, 128'h0);
      chk("rst_ic_data",  bus.ic_data_o,  128'h0);
      chk("rst_dc_data",  bus.dc_data_o,  128'h0);
      m_busy = 0; m_stage = 0; m_owner = 0; m_last_dc = 0;
      m_w = 1'b0; m_addr = '0; m_data = '0; m_line = '0;
      model_log.delete();
    end else begin
      dc_tie = !m_last_dc;
      e_icr  = !m_busy && (!bus.dc_v_i || !dc_tie);
      e_dcr  = !m_busy && (!bus.ic_v_i ||  dc_tie);
      chk("ic_ready", bus.ic_ready_o, e_icr);
      chk("dc_ready", bus.dc_ready_o, e_dcr);
      chk("mem_v",    bus.mem_v_o,    m_busy && m_stage == 0);
      chk("mem_yumi", bus.mem_yumi_o, m_busy && m_stage == 1);
      chk("ic_v",     bus.ic_v_o,     m_busy && m_stage == 2 && !m_owner);
      chk("dc_v",     bus.dc_v_o,     m_busy && m_stage == 2 &&  m_owner);
      chk("mem_w",    bus.mem_w_o,    m_w);
      chk("mem_addr", bus.mem_addr_o, m_addr);
      chk("mem_data", bus.mem_data_o, m_data);
      chk("ic_data",  bus.ic_data_o,  m_line);
      chk("dc_data",  bus.dc_data_o,  m_line);
      if (!m_busy) begin
        if (bus.ic_v_i && e_icr) begin
          m_busy = 1; m_stage = 0; m_owner = 0; m_last_dc = 0;
          m_w = 1'b0; m_addr = {bus.ic_addr_i[31:4], 4'h0}; m_data = '0;
          model_log.push_back(0);
        end else if (bus.dc_v_i && e_dcr) begin
          m_busy = 1; m_stage = 0; m_owner = 1; m_last_dc = 1;
          m_w = bus.dc_w_i; m_addr = {bus.dc_addr_i[31:4], 4'h0}; m_data = bus.dc_data_i;
          model_log.push_back(1);
        end
      end else begin
        yumi = m_owner ? bus.dc_yumi_i : bus.ic_yumi_i;
        if (m_stage == 0 && bus.mem_ready_i) m_stage = 1;
        else if (m_stage == 1 && bus.mem_v_i) begin m_line = bus.mem_data_i; m_stage = 2; end
        else if (m_stage == 2 && yumi) m_busy = 0;
      end
    end
  end

  // One complete request through the arbiter, with observed timing and fields.
  task automatic do_req(input bit is_dc, input bit w, input logic [31:0] addr,
                        input logic [127:0] data,
                        output int ca, output int cm, output int cr,
                        output int nm, output int nr,
                        output logic [31:0] ma, output logic mw,
                        output logic [127:0] md, output logic [127:0] rd);
    bit   done;
    logic rv;
    ca = -1; cm = -1; cr = -1; nm = 0; nr = 0;
    ma = '0; mw = 1'b0; md = '0; rd = '0; done = 0;
    @(posedge clk); #1;
    if (is_dc) begin
      bus.dc_v_i = 1'b1; bus.dc_w_i = w; bus.dc_addr_i = addr; bus.dc_data_i = data;
    end else begin
      bus.ic_v_i = 1'b1; bus.ic_addr_i = addr;
    end
    for (int k = 0; k < 80 && !done; k++) begin
      @(negedge clk);
      if (ca < 0 && (is_dc ? bus.dc_ready_o : bus.ic_ready_o)) ca = cyc;
      if (bus.mem_v_o) begin
        if (cm < 0) begin
          cm = cyc; ma = bus.mem_addr_o; mw = bus.mem_w_o; md = bus.mem_data_o;
        end
        nm++;
      end
      rv = is_dc ? bus.dc_v_o : bus.ic_v_o;
      if (rv) begin
        if (cr < 0) begin
          cr = cyc; rd = is_dc ? bus.dc_data_o : bus.ic_data_o;
        end
        nr++;
      end else if (cr >= 0) begin
        done = 1;
      end
      if (!done) begin
        @(posedge clk); #1;
        if (ca >= 0) begin bus.ic_v_i = 1'b0; bus.dc_v_i = 1'b0; end
      end
    end
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL req_timeout: no completed response, required one within 80 cycles");
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int ca, cm, cr, nm, nr, ng, p_dc, p_ic, p_icr;
    logic [31:0]  ma;
    logic         mw;
    logic [127:0] md, rd;
    bit           g_ic, g_dc;
    int           grants[4];
    int           gcyc[4];

    bus.ic_v_i = 1'b0; bus.ic_addr_i = '0;
    bus.dc_v_i = 1'b0; bus.dc_w_i = 1'b0; bus.dc_addr_i = '0; bus.dc_data_i = '0;
    bus_p.ic_v_i = 1'b0; bus_p.ic_addr_i = '0; bus_p.ic_yumi_i = 1'b0;
    bus_p.dc_v_i = 1'b0; bus_p.dc_w_i = 1'b0; bus_p.dc_addr_i = '0; bus_p.dc_data_i = '0;
    bus_p.dc_yumi_i = 1'b0; bus_p.mem_ready_i = 1'b0; bus_p.mem_v_i = 1'b0;
    bus_p.mem_data_i = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Icache read alone
    ready_dly = 0; resp_dly = 0; yumi_dly = 0; spurious = 0;
    resp_line = {16{8'hA5}};
    do_req(1'b0, 1'b0, 32'h0000_1234, '0, ca, cm, cr, nm, nr, ma, mw, md, rd);
    chk("t1_mem_addr", ma, 32'h0000_1230);
    chk("t1_mem_w",    mw, 1'b0);
    chk("t1_ic_data",  rd, {16{8'hA5}});
    chk("t1_mem_lat",  cm - ca, 1);
    chk("t1_rsp_lat",  cr - ca, 3);

    // Dcache write
    resp_line = {4{32'hDEAD_BEEF}};
    do_req(1'b1, 1'b1, 32'h0000_2000, {4{32'h1111_1111}}, ca, cm, cr, nm, nr, ma, mw, md, rd);
    chk("t2_mem_addr", ma, 32'h0000_2000);
    chk("t2_mem_w",    mw, 1'b1);
    chk("t2_mem_data", md, {4{32'h1111_1111}});
    chk("t2_dc_data",  rd, {4{32'hDEAD_BEEF}});
    chk("t2_rsp_lat",  cr - ca, 3);

    // Fresh reset so the first tie goes to dcache
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;

    // Both valid every cycle, round-robin
    resp_line = {4{32'h0BAD_CAFE}};
    bus.ic_addr_i = 32'h0000_0100; bus.dc_addr_i = 32'h0000_0200; bus.dc_w_i = 1'b0;
    bus.dc_data_i = '0;
    @(posedge clk); #1;
    bus.ic_v_i = 1'b1; bus.dc_v_i = 1'b1;
    ng = 0;
    for (int k = 0; k < 60 && ng < 4; k++) begin
      @(negedge clk);
      g_ic = bus.ic_v_i & bus.ic_ready_o;
      g_dc = bus.dc_v_i & bus.dc_ready_o;
      if (g_ic || g_dc) begin
        grants[ng] = g_dc ? 1 : 0;
        gcyc[ng] = cyc;
        ng++;
      end
      @(posedge clk); #1;
      if (g_ic) bus.ic_addr_i = bus.ic_addr_i + 32'h10;
      if (g_dc) bus.dc_addr_i = bus.dc_addr_i + 32'h10;
    end
    bus.ic_v_i = 1'b0; bus.dc_v_i = 1'b0;
    repeat (8) @(posedge clk);
    chk("t3_grant_count", ng, 4);
    if (ng == 4) begin
      chk("t3_grant0", grants[0], 1);
      chk("t3_grant1", grants[1], 0);
      chk("t3_grant2", grants[2], 1);
      chk("t3_grant3", grants[3], 0);
      chk("t3_spacing1", gcyc[1] - gcyc[0], 4);
      chk("t3_spacing2", gcyc[2] - gcyc[1], 4);
      chk("t3_spacing3", gcyc[3] - gcyc[2], 4);
    end
    chk("t3_model_len", model_log.size(), 4);
    if (model_log.size() == 4) begin
      chk("t3_model0", model_log[0], 1);
      chk("t3_model1", model_log[1], 0);
      chk("t3_model2", model_log[2], 1);
      chk("t3_model3", model_log[3], 0);
    end

    // Stalls on every handshake, with spurious mem_v_i during ISSUE
    ready_dly = 5; resp_dly = 7; yumi_dly = 3; spurious = 1;
    resp_line = {8{16'h5A3C}};
    do_req(1'b1, 1'b0, 32'h0000_345C, {4{32'h7777_0000}}, ca, cm, cr, nm, nr, ma, mw, md, rd);
    chk("t4_mem_addr",   ma, 32'h0000_3450);
    chk("t4_mem_data",   md, {4{32'h7777_0000}});
    chk("t4_issue_cyc",  nm, 6);
    chk("t4_resp_cyc",   nr, 4);
    chk("t4_rsp_lat",    cr - ca, 15);
    chk("t4_dc_data",    rd, {8{16'h5A3C}});
    ready_dly = 0; resp_dly = 0; yumi_dly = 0; spurious = 0;

    // Reset while waiting on memory
    resp_dly = 10;
    @(posedge clk); #1;
    bus.dc_v_i = 1'b1; bus.dc_w_i = 1'b0; bus.dc_addr_i = 32'h0000_4448;
    ca = -1;
    for (int k = 0; k < 10 && ca < 0; k++) begin
      @(negedge clk);
      if (bus.dc_ready_o) ca = cyc;
    end
    chk("t5_accepted", ca >= 0, 1'b1);
    @(posedge clk); #1;
    bus.dc_v_i = 1'b0;
    @(posedge clk); #3;
    chk("t5_in_wait", bus.mem_yumi_o, 1'b1);
    rst = 1'b1;
    #1;
    chk("t5_async_mem_v",    bus.mem_v_o,    1'b0);
    chk("t5_async_mem_yumi", bus.mem_yumi_o, 1'b0);
    chk("t5_async_ic_v",     bus.ic_v_o,     1'b0);
    chk("t5_async_dc_v",     bus.dc_v_o,     1'b0);
    chk("t5_async_mem_addr", bus.mem_addr_o, 32'h0);
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b0;
    resp_dly = 0;
    resp_line = {4{32'hC0FF_EE00}};
    do_req(1'b1, 1'b0, 32'h0000_5558, '0, ca, cm, cr, nm, nr, ma, mw, md, rd);
    chk("t5_mem_addr", ma, 32'h0000_5550);
    chk("t5_dc_data",  rd, {4{32'hC0FF_EE00}});
    chk("t5_rsp_lat",  cr - ca, 3);
    chk("t5_resp_cyc", nr, 1);

    // Fixed dcache priority instance, both valid every cycle
    bus_p.ic_addr_i = 32'h0000_0700; bus_p.dc_addr_i = 32'h0000_0800;
    bus_p.mem_data_i = {4{32'h1234_5678}}; bus_p.mem_ready_i = 1'b1;
    @(posedge clk); #1;
    bus_p.ic_v_i = 1'b1; bus_p.dc_v_i = 1'b1;
    p_dc = 0; p_ic = 0; p_icr = 0;
    for (int k = 0; k < 60 && p_dc < 4; k++) begin
      @(negedge clk);
      if (bus_p.ic_ready_o) p_icr++;
      if (bus_p.ic_v_i & bus_p.ic_ready_o) p_ic++;
      if (bus_p.dc_v_i & bus_p.dc_ready_o) p_dc++;
      @(posedge clk); #1;
      bus_p.mem_v_i   = bus_p.mem_yumi_o;
      bus_p.ic_yumi_i = bus_p.ic_v_o;
      bus_p.dc_yumi_i = bus_p.dc_v_o;
    end
    chk("p1_dc_grants", p_dc, 4);
    chk("p1_ic_grants", p_ic, 0);
    chk("p1_ic_ready",  p_icr, 0);
    bus_p.ic_v_i = 1'b0; bus_p.dc_v_i = 1'b0;

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
